// File: rtl/au_pkg.sv
// Shared definitions for the AU arithmetic blocks: operand FSM encoding and
// prefix-network index helpers used by the fast word adder.
package AU_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   // Number of prefix levels: log-depth for Kogge-Stone/Sklansky, serial for ripple.
   function automatic int pfx_levels(input int arch, input int width);
      if (width <= 1) return 0;
      return (arch == 2) ? width - 1 : $clog2(width);
   endfunction

   // Does bit i absorb a lower group at level k (k starts at 1)?
   function automatic bit pfx_comb(input int arch, input int k, input int i);
      case (arch)
         0:       return i >= (1 << (k - 1));
         1:       return ((i >> (k - 1)) & 1) == 1;
         default: return i == k;
      endcase
   endfunction

   // Index of the lower group bit combined into bit i at level k.
   function automatic int pfx_src(input int arch, input int k, input int i);
      case (arch)
         0:       return i - (1 << (k - 1));
         1:       return ((i >> (k - 1)) << (k - 1)) - 1;
         default: return k - 1;
      endcase
   endfunction

endpackage

// File: rtl/au_add_cfast.sv
// Combinational prefix adder, ARCH 0=Kogge-Stone, 1=Sklansky, 2=serial prefix.
// ci is folded into bit 0 generate so carry-in and carry-out sit on the fast path.
module AU_add_cfast
   import AU_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             cm
);

   localparam int NL = pfx_levels(ARCH, WIDTH);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] gp;
   logic [WIDTH:0]   cc;

   always_comb begin
      logic [WIDTH-1:0] g, p, gn, pn;
      logic [IW-1:0]    j;
      g     = a & b;
      p     = a ^ b;
      gn    = '0;
      pn    = '0;
      j     = '0;
      g[0]  = g[0] | (p[0] & ci);
      for (int k = 1; k <= NL; k++) begin
         gn = g;
         pn = p;
         for (int i = 0; i < WIDTH; i++) begin
            if (pfx_comb(ARCH, k, i)) begin
               j     = IW'(pfx_src(ARCH, k, i));
               gn[i] = g[i] | (p[i] & g[j]);
               pn[i] = p[i] & p[j];
            end
         end
         g = gn;
         p = pn;
      end
      gp = g;
   end

   // cc[i] is the carry into bit i; cc[WIDTH] is the word carry-out.
   assign cc = {gp, ci};
   assign s  = a ^ b ^ cc[WIDTH-1:0];
   assign co = cc[WIDTH];
   assign cm = cc[WIDTH-1];

endmodule

// File: rtl/au_add_mword.sv
// Streaming multi-word adder, LSW first; one-cycle latency, in_ready = !out_valid || out_ready.
// Optional two's-complement overflow output ov enabled by macro AU_ADD_MWORD_OVF_EN.
module au_add_mword
   import AU_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0,
   parameter int IDXW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_first,
   input  logic             in_last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             out_last,
   output logic [IDXW-1:0]  out_idx,
   output logic             co
`ifdef AU_ADD_MWORD_OVF_EN
   ,
   output logic             ov
`endif
);

   generate
      if (WIDTH < 1 || ARCH < 0 || ARCH > 2 || IDXW < 1) begin : g_bad_param
         $fatal(1, "au_add_mword: illegal parameters WIDTH=%0d ARCH=%0d IDXW=%0d",
                WIDTH, ARCH, IDXW);
      end
   endgenerate

   state_e           state;
   logic             carry;
   logic [IDXW-1:0]  idx_cnt;   // index the next non-first beat will carry
   logic             accept;
   logic             cin;
   logic [IDXW-1:0]  idx_sel;
   logic [WIDTH-1:0] sum;
   logic             wco;
   logic             msb_cin;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // A stray continuation beat with no operand open starts from carry 0.
   assign cin      = in_first ? ci : ((state == ACTIVE) && carry);
   assign idx_sel  = in_first ? '0 : idx_cnt;

   AU_add_cfast #(
      .WIDTH (WIDTH),
      .ARCH  (ARCH)
   ) u_add (
      .a  (a),
      .b  (b),
      .ci (cin),
      .s  (sum),
      .co (wco),
      .cm (msb_cin)
   );

`ifndef AU_ADD_MWORD_OVF_EN
   logic unused_msb_cin;
   assign unused_msb_cin = msb_cin;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         carry     <= 1'b0;
         idx_cnt   <= '0;
         out_valid <= 1'b0;
         s         <= '0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         co        <= 1'b0;
`ifdef AU_ADD_MWORD_OVF_EN
         ov        <= 1'b0;
`endif
      end else if (accept) begin
         out_valid <= 1'b1;
         s         <= sum;
         out_last  <= in_last;
         out_idx   <= idx_sel;
         co        <= in_last && wco;
`ifdef AU_ADD_MWORD_OVF_EN
         ov        <= in_last && (msb_cin ^ wco);
`endif
         carry     <= wco;
         idx_cnt   <= idx_sel + IDXW'(1);
         state     <= in_last ? IDLE : ACTIVE;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_au_add_mword.sv
// Directed bench for au_add_mword (WIDTH=8, IDXW=4): vector table plus
// hand-written backpressure, reset, index-wrap and overflow sequences.
module tb_au_add_mword;

   localparam int WIDTH = 8;
   localparam int IDXW  = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_first = 1'b0;
   logic             in_last = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             ci = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] s;
   logic             out_last;
   logic [IDXW-1:0]  out_idx;
   logic             co;
`ifdef AU_ADD_MWORD_OVF_EN
   logic             ov;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   au_add_mword #(
      .WIDTH (WIDTH),
      .ARCH  (0),
      .IDXW  (IDXW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .co        (co)
`ifdef AU_ADD_MWORD_OVF_EN
      ,
      .ov        (ov)
`endif
   );

   typedef struct {
      logic             f;
      logic             l;
      logic             ci;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      logic             co;
      logic [IDXW-1:0]  idx;
      logic             last;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic l, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic vci);
      in_valid = 1'b1;
      in_first = f;
      in_last  = l;
      a        = va;
      b        = vb;
      ci       = vci;
   endtask

   initial begin
      //            f     l     ci    a      b      s      co    idx   last
      vt[0]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 4'd0, 1'b1};
      vt[1]  = '{1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 4'd0, 1'b1};
      vt[2]  = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 8'h01, 1'b1, 4'd0, 1'b1};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 4'd0, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 4'd1, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 4'd2, 1'b1};
      vt[6]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 4'd0, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 4'd0, 1'b1};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b0, 4'd0, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'd1, 1'b1};
      vt[10] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 4'd2, 1'b1};
      vt[11] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h02, 1'b0, 4'd3, 1'b0};
      vt[12] = '{1'b0, 1'b1, 1'b0, 8'hFE, 8'h01, 8'hFF, 1'b0, 4'd4, 1'b1};

      // Reset state, with out_ready low to show in_ready is still 1.
      #1 rst_n = 1'b0;
      #2;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.s",         32'(s),         32'd0);
      chk("rst.out_last",  32'(out_last),  32'd0);
      chk("rst.out_idx",   32'(out_idx),   32'd0);
      chk("rst.co",        32'(co),        32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd1);
      step();
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();

      for (int i = 0; i < 13; i++) begin
         drive(vt[i].f, vt[i].l, vt[i].a, vt[i].b, vt[i].ci);
         step();
         chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d.s", i),         32'(s),         32'(vt[i].s));
         chk($sformatf("v%0d.co", i),        32'(co),        32'(vt[i].co));
         chk($sformatf("v%0d.out_idx", i),   32'(out_idx),   32'(vt[i].idx));
         chk($sformatf("v%0d.out_last", i),  32'(out_last),  32'(vt[i].last));
      end
      in_valid = 1'b0;
      step();
      chk("drain.out_valid", 32'(out_valid), 32'd0);

      // Backpressure: output holds for three stalled cycles, stalled beat survives.
      drive(1'b1, 1'b0, 8'h01, 8'h02, 1'b0);
      step();
      chk("bp.a.s", 32'(s), 32'h03);
      out_ready = 1'b0;
      drive(1'b0, 1'b1, 8'h05, 8'h06, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("bp.stall%0d.in_ready", i),  32'(in_ready),  32'd0);
         chk($sformatf("bp.stall%0d.out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp.stall%0d.s", i),         32'(s),         32'h03);
         chk($sformatf("bp.stall%0d.out_idx", i),   32'(out_idx),   32'd0);
         chk($sformatf("bp.stall%0d.out_last", i),  32'(out_last),  32'd0);
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp.b.s",        32'(s),        32'h0B);
      chk("bp.b.out_idx",  32'(out_idx),  32'd1);
      chk("bp.b.out_last", 32'(out_last), 32'd1);
      chk("bp.b.co",       32'(co),       32'd0);
      step();
      chk("bp.idle.out_valid", 32'(out_valid), 32'd0);

      // Reset mid-operand, then a continuation beat must see carry 0.
      drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("mrst.out_valid", 32'(out_valid), 32'd0);
      chk("mrst.s",         32'(s),         32'd0);
      chk("mrst.out_idx",   32'(out_idx),   32'd0);
      chk("mrst.in_ready",  32'(in_ready),  32'd1);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
      step();
      in_valid = 1'b0;
      chk("mrst.beat.s",       32'(s),       32'hFF);
      chk("mrst.beat.out_idx", 32'(out_idx), 32'd0);
      chk("mrst.beat.co",      32'(co),      32'd0);

      // Index counter wraps modulo 16.
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      step();
      chk("wrap.first.out_idx", 32'(out_idx), 32'd0);
      for (int n = 1; n <= 16; n++) begin
         drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
         step();
         chk($sformatf("wrap%0d.out_idx", n), 32'(out_idx), 32'(n % 16));
      end
      in_valid = 1'b0;
      step();

`ifdef AU_ADD_MWORD_OVF_EN
      drive(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
      step();
      in_valid = 1'b0;
      chk("ovf.ov", 32'(ov), 32'd1);
      chk("ovf.s",  32'(s),  32'h80);
      chk("ovf.co", 32'(co), 32'd0);
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/au_add_mword.md
AU_ADD_MWORD -- requirements
Module: AU_add_mword

Interface
- REQ-001 The module SHALL have parameter WIDTH, default 8, meaning word length of each beat (>= 1).
- REQ-002 The module SHALL have parameter ARCH, default 0, meaning the prefix architecture (0 to 2) passed to the word adder.
- REQ-003 The module SHALL have parameter IDXW, default 4, meaning the width of the word index counter (>= 1).
- REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
  - clk  input  1  clock, all state on the rising edge.
  - rst_n  input  1  reset, asynchronous, active-low.
  - in_valid  input  1  input beat valid.
  - in_ready  output  1  input beat accepted when high together with in_valid.
  - in_first  input  1  beat is the least-significant word of an operand.
  - in_last  input  1  beat is the most-significant word of an operand.
  - a  input  WIDTH  augend word.
  - b  input  WIDTH  addend word.
  - ci  input  1  operand carry-in, used only on a first beat.
  - out_valid  output  1  output beat valid.
  - out_ready  input  1  downstream accepts the output beat.
  - s  output  WIDTH  sum word.
  - out_last  output  1  sum word is the most-significant word.
  - out_idx  output  IDXW  word index within the operand, 0 on the first word.
  - co  output  1  final carry-out, meaningful only when out_last is high.

Function
- REQ-005 Operands SHALL be streamed least-significant word first; the block SHALL add one word pair per accepted beat.
- REQ-006 A beat SHALL be accepted when in_valid and in_ready are both high.
- REQ-007 in_ready SHALL be equal to (!out_valid || out_ready), so that the output register can be refilled in the same cycle it drains.
- REQ-008 Beat carry-in SHALL be ci when in_first is high, and the registered carry otherwise.
- REQ-009 On acceptance, the block SHALL register the sum word and the word carry-out; latency from acceptance to out_valid SHALL be one cycle.
- REQ-010 Sum arithmetic SHALL be modulo 2^WIDTH per word, with the word carry-out taken as bit WIDTH of a+b+carry_in.
- REQ-011 out_idx SHALL be 0 for a first beat and the previous index + 1 otherwise, wrapping modulo 2^IDXW.
- REQ-012 The output register (s, out_last, out_idx, co) SHALL hold its value while out_valid is high and out_ready is low.
- REQ-013 When out_ready is high and no beat is accepted, out_valid SHALL fall in the next cycle.
- REQ-014 A beat with both in_first and in_last high SHALL be a complete single-word add: carry-in is ci, and co is the word carry-out.
- REQ-015 A first beat arriving before the previous last beat SHALL abort the open operand: carry restarts from ci, index restarts at 0, and no error is flagged.
- REQ-016 A non-first beat arriving with no operand open (after reset or after a last beat) SHALL use carry 0 and continue the index count.
- REQ-017 The block SHALL have two states, IDLE (no operand open) and ACTIVE:
  - IDLE to ACTIVE on an accepted beat with in_last low.
  - ACTIVE to IDLE on an accepted beat with in_last high.
  - IDLE stays IDLE on an accepted beat with in_first and in_last both high.
- REQ-018 co SHALL be driven 0 whenever out_last is low.

Reset
- REQ-019 When rst_n is low, the block SHALL asynchronously clear the following to 0: out_valid, s, out_last, out_idx, co, the carry register and the index counter, and set the state to IDLE.
- REQ-020 A reset asserted mid-operand SHALL discard the operand; the first beat after reset SHALL be treated per REQ-016 unless in_first is high.
- REQ-021 in_ready SHALL be 1 while the block is in reset.

Configuration
- REQ-022 With macro AU_ADD_MWORD_OVF_EN defined, the block SHALL add output port ov (1 bit): two's-complement overflow of the full operand, equal to the XOR of the carry into the MSB and the carry out of the MSB of the last word, qualified by out_last, and reset to 0.
- REQ-023 Without AU_ADD_MWORD_OVF_EN, port ov and its logic SHALL be absent.

Structure
- REQ-024 The state encoding (IDLE, ACTIVE) SHALL be defined in shared package AU_pkg.
- REQ-025 Per-beat addition SHALL use one instance of sub-module AU_add_cfast (WIDTH, ARCH), with fast ci and co.
- REQ-026 Parameter legality (WIDTH >= 1, ARCH 0 to 2, IDXW >= 1) SHALL be checked at elaboration, and simulation SHALL abort on a violation.

Verification (WIDTH=8)
- REQ-027 Single word: first=last=1, a=0xFF, b=0x01, ci=0 -> one cycle later s=0x00, co=1, out_idx=0, out_last=1.
- REQ-028 Three words: a=0x00FFFF, b=0x000001, ci=0 -> s=0x00, 0x00, 0x01, co=0, out_idx=0, 1, 2.
- REQ-029 Backpressure: out_ready held low 3 cycles -> in_ready=0, output holds stable, and no beat is lost.
- REQ-030 Abort: first beat, then a new first beat with ci=1, a=0x10, b=0x20 -> s=0x31 and out_idx=0, with no stale carry used.
- REQ-031 Reset mid-operand -> all outputs 0; then a non-first beat with a=0xFF, b=0x00 -> s=0xFF, confirming carry 0.
- REQ-032 With AU_ADD_MWORD_OVF_EN: first=last=1, a=0x7F, b=0x01 -> ov=1, s=0x80, co=0.
